// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control logic:
// FSM state encoding and register-index constants.
package hazard_stall_unit_pkg;

   localparam int unsigned RegIdxW = 5;
   localparam logic [RegIdxW-1:0] RegZero = '0;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StMduWait = 2'd2
   } hazard_state_e;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use compare: the instruction in EX is a load whose
// destination is read by the instruction in ID.
module hazard_loaduse_detect
   import hazard_stall_unit_pkg::*;
(
   input  logic [RegIdxW-1:0] rs1_i,
   input  logic [RegIdxW-1:0] rs2_i,
   input  logic               use_rs1_i,
   input  logic               use_rs2_i,
   input  logic [RegIdxW-1:0] rd_i,
   input  logic               mem_read_i,
   output logic               stall_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = use_rs1_i && (rs1_i == rd_i);
   assign rs2_hit = use_rs2_i && (rs2_i == rd_i);

   // x0 is hard-wired, so a load targeting it never produces a dependency.
   assign stall_o = mem_read_i && (rd_i != RegZero) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/flush controller: load-use bubbles, taken-branch flushes,
// data-memory wait states and multicycle MDU occupancy.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [RegIdxW-1:0]     IF_ID_rs1,
   input  logic [RegIdxW-1:0]     IF_ID_rs2,
   input  logic                   IF_ID_UseRs1,
   input  logic                   IF_ID_UseRs2,
   input  logic [RegIdxW-1:0]     ID_EX_rd,
   input  logic                   ID_EX_MemRead,
   input  logic                   EX_BranchTaken,
   input  logic                   EX_MduStart,
   input  logic                   MduDone,
   input  logic                   MEM_Req,
   input  logic                   MEM_Ready,
   output logic                   PCWrite,
   output logic                   IF_ID_Write,
   output logic                   ID_EX_Write,
   output logic                   EX_MEM_Write,
   output logic                   IF_ID_Flush,
   output logic                   ID_EX_Flush,
   output logic                   EX_MEM_Flush,
   output logic                   MEM_WB_Flush,
   output logic                   MemTimeout,
   output logic [STALL_CNT_W-1:0] StallCount
);

   localparam logic [15:0] TimeoutCnt = 16'(MEM_TIMEOUT);

   hazard_state_e          state_q, state_d;
   logic                   mdu_pending_q, mdu_pending_d;
   logic [15:0]            wait_cnt_q, wait_cnt_d;
   logic                   mem_timeout_q, mem_timeout_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   load_use;

   hazard_loaduse_detect u_loaduse (
      .rs1_i      (IF_ID_rs1),
      .rs2_i      (IF_ID_rs2),
      .use_rs1_i  (IF_ID_UseRs1),
      .use_rs2_i  (IF_ID_UseRs2),
      .rd_i       (ID_EX_rd),
      .mem_read_i (ID_EX_MemRead),
      .stall_o    (load_use)
   );

   always_comb begin
      state_d       = state_q;
      mdu_pending_d = mdu_pending_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      PCWrite       = 1'b1;
      IF_ID_Write   = 1'b1;
      ID_EX_Write   = 1'b1;
      EX_MEM_Write  = 1'b1;
      IF_ID_Flush   = 1'b0;
      ID_EX_Flush   = 1'b0;
      EX_MEM_Flush  = 1'b0;
      MEM_WB_Flush  = 1'b0;

      unique case (state_q)
         StRun: begin
            if (MEM_Req && !MEM_Ready) begin
               // Whole front end freezes; a coincident branch simply re-asserts later.
               PCWrite       = 1'b0;
               IF_ID_Write   = 1'b0;
               ID_EX_Write   = 1'b0;
               EX_MEM_Write  = 1'b0;
               MEM_WB_Flush  = 1'b1;
               state_d       = StMemWait;
               wait_cnt_d    = '0;
               if (EX_MduStart) mdu_pending_d = 1'b1;
            end else if (EX_BranchTaken) begin
               IF_ID_Flush = 1'b1;
               ID_EX_Flush = 1'b1;
            end else if (EX_MduStart && !MduDone) begin
               PCWrite      = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Flush = 1'b1;
               state_d      = StMduWait;
            end else if (load_use) begin
               PCWrite     = 1'b0;
               IF_ID_Write = 1'b0;
               ID_EX_Flush = 1'b1;
            end
         end
         StMemWait: begin
            if (MduDone) mdu_pending_d = 1'b0;
            if (MEM_Ready) begin
               state_d = (mdu_pending_q && !MduDone) ? StMduWait : StRun;
            end else begin
               PCWrite      = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Write = 1'b0;
               MEM_WB_Flush = 1'b1;
               if (wait_cnt_q != TimeoutCnt) wait_cnt_d = wait_cnt_q + 16'd1;
               if (wait_cnt_d == TimeoutCnt) mem_timeout_d = 1'b1;
            end
         end
         StMduWait: begin
            mdu_pending_d = 1'b0;
            if (MduDone) begin
               state_d = StRun;
            end else begin
               PCWrite      = 1'b0;
               IF_ID_Write  = 1'b0;
               ID_EX_Write  = 1'b0;
               EX_MEM_Flush = 1'b1;
            end
         end
         default: state_d = StRun;
      endcase

      // Reset overrides any decoded hazard so the pipeline registers can clear.
      if (!rst_n) begin
         PCWrite      = 1'b1;
         IF_ID_Write  = 1'b1;
         ID_EX_Write  = 1'b1;
         EX_MEM_Write = 1'b1;
         IF_ID_Flush  = 1'b0;
         ID_EX_Flush  = 1'b0;
         EX_MEM_Flush = 1'b0;
         MEM_WB_Flush = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StRun;
         mdu_pending_q <= 1'b0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         mdu_pending_q <= mdu_pending_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign MemTimeout = mem_timeout_q;
   assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed scoreboard bench for hazard_stall_unit: expected control vectors
// are queued per driven cycle and compared mid-cycle against the DUT.
module tb_hazard_stall_unit;

   localparam int unsigned MemTimeoutP = 4;
   localparam int unsigned StallW      = 16;

   // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
   //  IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush}
   localparam logic [7:0] ExpRun  = 8'b1111_0000;
   localparam logic [7:0] ExpMem  = 8'b0000_0001;
   localparam logic [7:0] ExpMdu  = 8'b0001_0010;
   localparam logic [7:0] ExpLu   = 8'b0011_0100;
   localparam logic [7:0] ExpBr   = 8'b1111_1100;

   typedef struct {
      string       tag;
      logic [7:0]  outs;
      logic        to;
      logic [15:0] sc;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [4:0]        IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
   logic              IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead;
   logic              EX_BranchTaken, EX_MduStart, MduDone, MEM_Req, MEM_Ready;
   logic              PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
   logic              IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
   logic              MemTimeout;
   logic [StallW-1:0] StallCount;
   logic [7:0]        dut_outs;

   exp_t        sb[$];
   int          n_checks;
   int          n_errors;
   logic        exp_to;
   logic [15:0] exp_sc;

   hazard_stall_unit #(
      .MEM_TIMEOUT (MemTimeoutP),
      .STALL_CNT_W (StallW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .IF_ID_rs1      (IF_ID_rs1),
      .IF_ID_rs2      (IF_ID_rs2),
      .IF_ID_UseRs1   (IF_ID_UseRs1),
      .IF_ID_UseRs2   (IF_ID_UseRs2),
      .ID_EX_rd       (ID_EX_rd),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .EX_BranchTaken (EX_BranchTaken),
      .EX_MduStart    (EX_MduStart),
      .MduDone        (MduDone),
      .MEM_Req        (MEM_Req),
      .MEM_Ready      (MEM_Ready),
      .PCWrite        (PCWrite),
      .IF_ID_Write    (IF_ID_Write),
      .ID_EX_Write    (ID_EX_Write),
      .EX_MEM_Write   (EX_MEM_Write),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Flush    (ID_EX_Flush),
      .EX_MEM_Flush   (EX_MEM_Flush),
      .MEM_WB_Flush   (MEM_WB_Flush),
      .MemTimeout     (MemTimeout),
      .StallCount     (StallCount)
   );

   assign dut_outs = {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                      IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Inputs change on the falling edge; the expected vector for that cycle is queued.
   task automatic drv(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                      input logic br, input logic ms, input logic md, input logic mreq,
                      input logic mrdy, input logic [7:0] exp_outs, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n          = rst;
      IF_ID_rs1      = rs1;
      IF_ID_rs2      = rs2;
      IF_ID_UseRs1   = u1;
      IF_ID_UseRs2   = u2;
      ID_EX_rd       = rd;
      ID_EX_MemRead  = mr;
      EX_BranchTaken = br;
      EX_MduStart    = ms;
      MduDone        = md;
      MEM_Req        = mreq;
      MEM_Ready      = mrdy;
      e.tag  = tag;
      e.outs = exp_outs;
      e.to   = exp_to;
      e.sc   = exp_sc;
      sb.push_back(e);
      if (!rst) begin
         exp_sc = '0;
         exp_to = 1'b0;
      end else if (!exp_outs[7] && exp_sc != 16'hffff) begin
         exp_sc = exp_sc + 16'd1;
      end
   endtask

   task automatic idle(input string tag);
      drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpRun, tag);
   endtask

   task automatic mem(input logic rdy, input logic ms, input logic md, input logic [7:0] exp_outs,
                      input string tag);
      drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ms, md, 1'b1, rdy, exp_outs, tag);
   endtask

   task automatic mdu(input logic ms, input logic md, input logic [7:0] exp_outs,
                      input string tag);
      drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ms, md, 1'b0, 1'b0, exp_outs, tag);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, "/outs"}, 32'(dut_outs), 32'(e.outs));
            check_val({e.tag, "/timeout"}, 32'(MemTimeout), 32'(e.to));
            check_val({e.tag, "/stallcnt"}, 32'(StallCount), 32'(e.sc));
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      exp_to   = 1'b0;
      exp_sc   = '0;
      rst_n = 1'b0;
      IF_ID_rs1 = '0; IF_ID_rs2 = '0; IF_ID_UseRs1 = 1'b0; IF_ID_UseRs2 = 1'b0;
      ID_EX_rd = '0; ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; EX_MduStart = 1'b0;
      MduDone = 1'b0; MEM_Req = 1'b0; MEM_Ready = 1'b0;
      repeat (2) @(posedge clk);

      idle("reset_state");

      // Load-use on rs2, then the bubble clears it.
      drv(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpLu, "lu_rs2");
      idle("lu_after");
      drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpRun, "lu_x0");
      drv(1'b1, 5'd7, 5'd3, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpLu, "lu_rs1");
      drv(1'b1, 5'd7, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpRun,
          "lu_nouse");
      drv(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpRun,
          "lu_noload");

      // Taken branch wins over a coincident load-use.
      drv(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ExpBr, "br_lu");
      idle("br_after");

      // Memory wait: three frozen cycles, release on Ready.
      for (int i = 0; i < 3; i++) mem(1'b0, 1'b0, 1'b0, ExpMem, $sformatf("memw%0d", i));
      mem(1'b1, 1'b0, 1'b0, ExpRun, "mem_release");
      idle("mem_after");

      // Memory stall with a deferred MDU launch; MduDone six cycles after Ready.
      mem(1'b0, 1'b1, 1'b0, ExpMem, "memmdu_enter");
      mem(1'b0, 1'b0, 1'b0, ExpMem, "memmdu_wait");
      mem(1'b1, 1'b0, 1'b0, ExpRun, "memmdu_ready");
      for (int i = 0; i < 5; i++) mdu(1'b0, 1'b0, ExpMdu, $sformatf("mduw%0d", i));
      mdu(1'b0, 1'b1, ExpRun, "mdu_done");
      idle("memmdu_after");

      // Direct MDU occupancy, and a start that completes in the same cycle.
      mdu(1'b1, 1'b0, ExpMdu, "mdu_start");
      mdu(1'b0, 1'b1, ExpRun, "mdu_done2");
      mdu(1'b1, 1'b1, ExpRun, "mdu_instant");
      idle("mdu_after");

      // Timeout: entry cycle plus four wait cycles, then the sticky flag.
      mem(1'b0, 1'b0, 1'b0, ExpMem, "to_enter");
      for (int i = 0; i < 4; i++) mem(1'b0, 1'b0, 1'b0, ExpMem, $sformatf("to_w%0d", i));
      exp_to = 1'b1;
      mem(1'b0, 1'b0, 1'b0, ExpMem, "to_set");
      mem(1'b1, 1'b0, 1'b0, ExpRun, "to_release");
      idle("to_sticky");

      // Reset while the MDU is busy; the late MduDone must be ignored.
      mdu(1'b1, 1'b0, ExpMdu, "rst_mdu_enter");
      mdu(1'b0, 1'b0, ExpMdu, "rst_mdu_wait");
      drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ExpRun,
          "rst_assert");
      idle("rst_run");
      mdu(1'b0, 1'b1, ExpRun, "rst_late_done");
      idle("rst_final");

      @(negedge clk);
      #3;
      check_val("sb_drain", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
